// File: rtl/avalon_reg_master.sv
// Avalon-MM master for single 32-bit register reads/writes, one command in flight at a time.
// Define AVALON_MASTER_TIMEOUT_EN to abort transactions stalled on waitrequest for TIMEOUT_CYCLES.
module avalon_reg_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
`ifdef AVALON_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avalon_master_address,
  output logic              avalon_master_write,
  output logic [DATA_W-1:0] avalon_master_writedata,
  output logic              avalon_master_read,
  input  logic [DATA_W-1:0] avalon_master_readdata,
  input  logic              avalon_master_waitrequest
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              cmd_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_readdata_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] writedata_d;
  logic              write_d;
  logic              read_d;

`ifdef AVALON_MASTER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             error_q, error_d;
  assign rsp_error = error_q;
`else
  assign rsp_error = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = cmd_ready;
    rsp_valid_d    = rsp_valid;
    rsp_readdata_d = rsp_readdata;
    address_d      = avalon_master_address;
    writedata_d    = avalon_master_writedata;
    write_d        = avalon_master_write;
    read_d         = avalon_master_read;
`ifdef AVALON_MASTER_TIMEOUT_EN
    wait_cnt_d     = wait_cnt_q;
    error_d        = error_q;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_ready && cmd_valid) begin
          cmd_ready_d = 1'b0;
          address_d   = cmd_address;
          writedata_d = cmd_writedata;
          write_d     = cmd_write;
          read_d      = !cmd_write;
          state_d     = cmd_write ? WRITE : READ;
`ifdef AVALON_MASTER_TIMEOUT_EN
          wait_cnt_d  = '0;
`endif
        end
      end
      WRITE, READ: begin
        // A completing cycle takes priority over reaching the timeout limit.
        if (!avalon_master_waitrequest) begin
          write_d        = 1'b0;
          read_d         = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = (state_q == READ) ? avalon_master_readdata : '0;
          state_d        = RESP;
`ifdef AVALON_MASTER_TIMEOUT_EN
          error_d        = 1'b0;
`endif
        end
`ifdef AVALON_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          write_d        = 1'b0;
          read_d         = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = '1;
          error_d        = 1'b1;
          state_d        = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                 <= IDLE;
      cmd_ready               <= 1'b0;
      rsp_valid               <= 1'b0;
      rsp_readdata            <= '0;
      avalon_master_address   <= '0;
      avalon_master_writedata <= '0;
      avalon_master_write     <= 1'b0;
      avalon_master_read      <= 1'b0;
`ifdef AVALON_MASTER_TIMEOUT_EN
      wait_cnt_q              <= '0;
      error_q                 <= 1'b0;
`endif
    end else begin
      state_q                 <= state_d;
      cmd_ready               <= cmd_ready_d;
      rsp_valid               <= rsp_valid_d;
      rsp_readdata            <= rsp_readdata_d;
      avalon_master_address   <= address_d;
      avalon_master_writedata <= writedata_d;
      avalon_master_write     <= write_d;
      avalon_master_read      <= read_d;
`ifdef AVALON_MASTER_TIMEOUT_EN
      wait_cnt_q              <= wait_cnt_d;
      error_q                 <= error_d;
`endif
    end
  end

endmodule

// File: tb/tb_avalon_reg_master.sv
// Bench for avalon_reg_master: scripted slave with programmable wait states and a response scoreboard.
module tb_avalon_reg_master;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_address = '0;
  logic [31:0] cmd_writedata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_readdata;
  logic        rsp_error;
  logic [15:0] avalon_master_address;
  logic        avalon_master_write;
  logic [31:0] avalon_master_writedata;
  logic        avalon_master_read;
  logic [31:0] avalon_master_readdata;
  logic        avalon_master_waitrequest;

  int          vectors = 0;
  int          miscompares = 0;
  int          wait_cfg = 0;
  bit          stuck = 1'b0;
  logic [31:0] rd_value = '0;
  int          busy = 0;
  int          bus_total = 0;
  logic [15:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [32:0] scoreboard[$];

  avalon_reg_master #(
    .ADDR_W(16),
    .DATA_W(32)
`ifdef AVALON_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_address(cmd_address),
    .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_readdata(rsp_readdata),
    .rsp_error(rsp_error),
    .avalon_master_address(avalon_master_address),
    .avalon_master_write(avalon_master_write),
    .avalon_master_writedata(avalon_master_writedata),
    .avalon_master_read(avalon_master_read),
    .avalon_master_readdata(avalon_master_readdata),
    .avalon_master_waitrequest(avalon_master_waitrequest)
  );

  always #5 clock = ~clock;

  // Slave stalls for wait_cfg cycles of each transfer; readdata is garbage while stalled.
  always @(posedge clock) begin
    if (reset || !(avalon_master_read || avalon_master_write)) busy <= 0;
    else busy <= busy + 1;
  end
  assign avalon_master_waitrequest = stuck || ((avalon_master_read || avalon_master_write) && busy < wait_cfg);
  assign avalon_master_readdata = avalon_master_waitrequest ? 32'hDEAD_BEEF : rd_value;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && (avalon_master_write || avalon_master_read)) begin
      bus_total <= bus_total + 1;
      checkOutput("rw_exclusive", 64'(avalon_master_write && avalon_master_read), 64'd0);
      checkOutput("bus_address", 64'(avalon_master_address), 64'(exp_addr));
      if (avalon_master_write) checkOutput("bus_writedata", 64'(avalon_master_writedata), 64'(exp_wdata));
    end
  end

  // Runs one command; called and returns at 1 time unit after a rising edge.
  task automatic applyStimulus(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                               input int waits, input bit hang, input int hold);
    int n;
    int bus_start;
    int exp_lat;
    int exp_bus;
    logic [32:0] exp_rsp;
    logic [32:0] got;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clock); #1; n++;
    end
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    wait_cfg = waits;
    stuck = hang;
    exp_addr = addr;
    exp_wdata = data;
    exp_lat = hang ? TO + 1 : waits + 2;
    exp_bus = hang ? TO : waits + 1;
    exp_rsp = hang ? {1'b1, 32'hFFFF_FFFF} : {1'b0, (wr ? 32'd0 : rd_value)};
    scoreboard.push_back(exp_rsp);
    cmd_write = wr;
    cmd_address = addr;
    cmd_writedata = data;
    cmd_valid = 1'b1;
    bus_start = bus_total;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    checkOutput("bus_start", 64'({avalon_master_write, avalon_master_read}), wr ? 64'd2 : 64'd1);
    n = 1;
    while (!rsp_valid && n < 400) begin
      @(posedge clock); #1; n++;
    end
    stuck = 1'b0;
    checkOutput("rsp_latency", 64'(n), 64'(exp_lat));
    checkOutput("bus_cycles", 64'(bus_total - bus_start), 64'(exp_bus));
    if (scoreboard.size() > 0) begin
      exp_rsp = scoreboard.pop_front();
      got = {rsp_error, rsp_readdata};
      checkOutput("rsp_data", 64'(got), 64'(exp_rsp));
    end
    // While the response is pending, a new command must be ignored.
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_address = 16'hFFFF;
      @(posedge clock); #1;
      checkOutput("hold_rsp", 64'({rsp_valid, cmd_ready, avalon_master_write, rsp_error, rsp_readdata}),
                  64'({1'b1, 1'b0, 1'b0, exp_rsp}));
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("rsp_taken", 64'({rsp_valid, cmd_ready, avalon_master_write, avalon_master_read}), 64'b0100);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_state", 64'({cmd_ready, rsp_valid, avalon_master_read, avalon_master_write, rsp_error}), 64'd0);
    checkOutput("reset_regs", 64'({avalon_master_address, avalon_master_writedata, rsp_readdata}), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("ready_after_reset", 64'(cmd_ready), 64'd1);

    applyStimulus(1'b1, 16'h0100, 32'h1234_5678, 0, 1'b0, 0);
    rd_value = 32'd4;
    applyStimulus(1'b0, 16'h0300, 32'h0, 1, 1'b0, 0);
    applyStimulus(1'b1, 16'h0200, 32'hA5A5_5A5A, 5, 1'b0, 0);
    rd_value = 32'hCAFE_F00D;
    applyStimulus(1'b0, 16'h0400, 32'h0, 1, 1'b0, 10);
    for (int k = 0; k < 4; k++) begin
      rd_value = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), $urandom, $urandom_range(0, 3), 1'b0, $urandom_range(0, 2));
    end

    // Reset during a stalled read drops the transfer and discards the command.
    wait_cfg = 5;
    exp_addr = 16'h0300;
    cmd_write = 1'b0;
    cmd_address = 16'h0300;
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    checkOutput("read_in_wait", 64'(avalon_master_read), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("reset_mid_read", 64'({avalon_master_read, rsp_valid, cmd_ready}), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("ready_after_abort", 64'({cmd_ready, avalon_master_read, rsp_valid}), 64'b100);

    rd_value = 32'h0000_0077;
    applyStimulus(1'b0, 16'h0100, 32'h0, 0, 1'b0, 0);
`ifdef AVALON_MASTER_TIMEOUT_EN
    applyStimulus(1'b0, 16'h0500, 32'h0, 0, 1'b1, 1);
    applyStimulus(1'b1, 16'h0600, 32'h1111_2222, 0, 1'b1, 0);
    applyStimulus(1'b1, 16'h0700, 32'h3333_4444, TO - 1, 1'b0, 0);
`endif
    checkOutput("scoreboard_empty", 64'(scoreboard.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
